// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the pipeline control block:
//   state_t     - memory-wait FSM encoding (ST_RUN, ST_MEM_WAIT)
//   FWD_*       - ALU operand forward-select codes
//   fwd_select  - priority pick of a forward source for one operand
// Build option: FORWARD_EN (see hazard_detect / pipeline_hazard_ctrl).
package cpu_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // The youngest producer wins: a non-load in EX beats whatever sits in MEM.
    // A load in EX has no result yet, so it falls through to the MEM check.
    function automatic logic [1:0] fwd_select(input logic ex_hit,
                                              input logic ex_is_load,
                                              input logic mem_hit);
        if (ex_hit && !ex_is_load) return FWD_MEM;
        else if (mem_hit)          return FWD_WB;
        else                       return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Combinational register-compare between the instruction in ID and the
// writers in EX and MEM.
// Ports:
//   id_rs, id_rt         in  source registers of the ID instruction
//   id_use_rs, id_use_rt in  ID instruction really reads rs / rt
//   ex_rd, mem_rd        in  destination registers in EX / MEM
//   ex_regwrite          in  EX instruction writes a register
//   mem_regwrite         in  MEM instruction writes a register
//   ex_memread           in  EX instruction is a load
//   data_stall           out ID must hold and a bubble goes into EX
//   fwd_a, fwd_b         out operand forward selects
// Build option FORWARD_EN: when defined, only load-use stalls and operands
// are forwarded; otherwise every RAW stalls and the selects stay FWD_NONE.
module hazard_detect
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              ex_memread,
    output logic              data_stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

    assign ex_hit_a  = id_use_rs && ex_regwrite  && (ex_rd  != '0) && (id_rs == ex_rd);
    assign ex_hit_b  = id_use_rt && ex_regwrite  && (ex_rd  != '0) && (id_rt == ex_rd);
    assign mem_hit_a = id_use_rs && mem_regwrite && (mem_rd != '0) && (id_rs == mem_rd);
    assign mem_hit_b = id_use_rt && mem_regwrite && (mem_rd != '0) && (id_rt == mem_rd);

`ifdef FORWARD_EN
    assign data_stall = ex_memread && (ex_hit_a || ex_hit_b);
    assign fwd_a      = fwd_select(ex_hit_a, ex_memread, mem_hit_a);
    assign fwd_b      = fwd_select(ex_hit_b, ex_memread, mem_hit_b);
`else
    // Without a bypass network the reader waits until the writer is in WB.
    logic unused_memread;
    assign unused_memread = ex_memread;
    assign data_stall = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
    assign fwd_a      = FWD_NONE;
    assign fwd_b      = FWD_NONE;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Drives the write-enable / flush pairs of the four inter-stage registers of
// the 5-stage CPU, plus the PC write enable. Holds the memory-wait FSM, the
// memory watchdog and the stall performance counter.
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   id_rs, id_rt, id_use_rs/rt     ID source operands
//   ex_rd, mem_rd, ex/mem_regwrite writers in EX / MEM
//   ex_memread, ex_br_taken        EX is a load / EX resolved a taken branch
//   dmem_req, dmem_ready           data memory handshake from MEM
//   pc_we, {ifid,idex,exmem,memwb}_{we,flush}  register controls
//   fwd_a, fwd_b                   operand forward selects
//   mem_timeout                    sticky watchdog error
//   stall_cycles                   cycles with pc_we=0
// Build option FORWARD_EN enables operand forwarding (see hazard_detect).
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              ex_memread,
    input  logic              ex_br_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_we,
    output logic              idex_flush,
    output logic              exmem_we,
    output logic              exmem_flush,
    output logic              memwb_we,
    output logic              memwb_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int              CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             data_stall;
    logic [1:0]       hd_fwd_a, hd_fwd_b;
    logic             mem_stall;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .ex_rd       (ex_rd),
        .mem_rd      (mem_rd),
        .ex_regwrite (ex_regwrite),
        .mem_regwrite(mem_regwrite),
        .ex_memread  (ex_memread),
        .data_stall  (data_stall),
        .fwd_a       (hd_fwd_a),
        .fwd_b       (hd_fwd_b)
    );

    // A pending access stalls in either FSM state; a ready access advances.
    assign mem_stall = dmem_req && !dmem_ready;

    // Priority: memory stall, then branch flush, then data stall, then advance.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_we     = 1'b0;
        idex_flush  = 1'b0;
        exmem_we    = 1'b0;
        exmem_flush = 1'b0;
        memwb_we    = 1'b0;
        memwb_flush = 1'b0;
        fwd_a       = FWD_NONE;
        fwd_b       = FWD_NONE;
        if (!rst) begin
            fwd_a = hd_fwd_a;
            fwd_b = hd_fwd_b;
            if (mem_stall) begin
                // Front of the pipe freezes; WB receives a bubble.
                memwb_we    = 1'b1;
                memwb_flush = 1'b1;
            end else if (ex_br_taken) begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                ifid_flush = 1'b1;
                idex_we    = 1'b1;
                idex_flush = 1'b1;
                exmem_we   = 1'b1;
                memwb_we   = 1'b1;
            end else if (data_stall) begin
                idex_we    = 1'b1;
                idex_flush = 1'b1;
                exmem_we   = 1'b1;
                memwb_we   = 1'b1;
            end else begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
                memwb_we = 1'b1;
            end
        end
    end

    // The watchdog counts MEM_WAIT cycles still without ready, saturating at
    // MEM_TIMEOUT; the error flag stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (!pc_we) stall_cycles <= stall_cycles + PERF_W'(1);
            case (state)
                ST_RUN: begin
                    wait_cnt <= '0;
                    if (mem_stall) state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= ST_RUN;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if ((wait_cnt + CNT_W'(1)) == CNT_MAX) mem_timeout <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// hand-computed expectations, then randomized stimulus compared every cycle
// against a behavioural model. Honours FORWARD_EN the same way as the RTL.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_use_rs, id_use_rt, ex_regwrite, mem_regwrite, ex_memread;
    logic        ex_br_taken, dmem_req, dmem_ready;
    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
    logic        exmem_we, exmem_flush, memwb_we, memwb_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;
    bit compare_en = 1'b0;

    // Model state: are we waiting on memory, how long, error flag, stall count.
    bit          m_waiting;
    int          m_cnt;
    bit          m_timeout;
    logic [31:0] m_stalls;

    pipeline_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(TO), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_regwrite(ex_regwrite),
        .mem_regwrite(mem_regwrite), .ex_memread(ex_memread),
        .ex_br_taken(ex_br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_flush(idex_flush),
        .exmem_we(exmem_we), .exmem_flush(exmem_flush),
        .memwb_we(memwb_we), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit hit(input bit used, input bit wr,
                               input logic [4:0] src, input logic [4:0] rd);
        return used && wr && (rd != 5'd0) && (src == rd);
    endfunction

    function bit exp_data_stall();
        bit ex_any, mem_any;
        ex_any  = hit(id_use_rs, ex_regwrite, id_rs, ex_rd) || hit(id_use_rt, ex_regwrite, id_rt, ex_rd);
        mem_any = hit(id_use_rs, mem_regwrite, id_rs, mem_rd) || hit(id_use_rt, mem_regwrite, id_rt, mem_rd);
`ifdef FORWARD_EN
        return ex_memread && ex_any;
`else
        return ex_any || mem_any;
`endif
    endfunction

    // Expected controls, packed as {pc,ifid_we,ifid_fl,idex_we,idex_fl,exmem_we,exmem_fl,memwb_we,memwb_fl}.
    function logic [8:0] exp_ctl();
        if (rst)                         return 9'b0_00_00_00_00;
        else if (dmem_req && !dmem_ready) return 9'b0_00_00_00_11;
        else if (ex_br_taken)            return 9'b1_11_11_10_10;
        else if (exp_data_stall())       return 9'b0_00_11_10_10;
        else                             return 9'b1_10_10_10_10;
    endfunction

    function logic [1:0] exp_fwd(input bit used, input logic [4:0] src);
        if (rst) return 2'b00;
`ifdef FORWARD_EN
        if (hit(used, ex_regwrite, src, ex_rd) && !ex_memread) return 2'b10;
        if (hit(used, mem_regwrite, src, mem_rd))              return 2'b01;
`endif
        return 2'b00;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_waiting <= 1'b0;
            m_cnt     <= 0;
            m_timeout <= 1'b0;
            m_stalls  <= 32'd0;
        end else begin
            logic [8:0] c;
            c = exp_ctl();
            if (!c[8]) m_stalls <= m_stalls + 32'd1;
            if (!m_waiting) begin
                m_cnt     <= 0;
                m_waiting <= dmem_req && !dmem_ready;
            end else if (dmem_ready) begin
                m_waiting <= 1'b0;
            end else if (m_cnt < TO) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 >= TO) m_timeout <= 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (compare_en) begin
            logic [8:0] act, exp;
            act = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                   exmem_we, exmem_flush, memwb_we, memwb_flush};
            exp = exp_ctl();
            checks++;
            if (act !== exp || fwd_a !== exp_fwd(id_use_rs, id_rs) ||
                fwd_b !== exp_fwd(id_use_rt, id_rt) ||
                mem_timeout !== m_timeout || stall_cycles !== m_stalls) begin
                failures++;
                $display("[TB] FAIL model_cycle t=%0t ctl=%b/%b fwd_a=%0d/%0d fwd_b=%0d/%0d timeout=%0d/%0d stalls=%0d/%0d (actual/required)",
                         $time, act, exp, fwd_a, exp_fwd(id_use_rs, id_rs),
                         fwd_b, exp_fwd(id_use_rt, id_rt),
                         mem_timeout, m_timeout, stall_cycles, m_stalls);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_rd = 5'd0; mem_rd = 5'd0; ex_regwrite = 1'b0; mem_regwrite = 1'b0;
        ex_memread = 1'b0; ex_br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs set by the caller settle until the falling edge, where checks run;
    // the following rising edge then commits the cycle.
    task automatic applyStimulus();
        @(negedge clk);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clearInputs();
        applyStimulus();
        checkOutput("reset_pc_we", {31'd0, pc_we}, 32'd0);
        checkOutput("reset_memwb_we", {31'd0, memwb_we}, 32'd0);
        checkOutput("reset_stall_cycles", stall_cycles, 32'd0);
        checkOutput("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        nextCycle();
        rst = 1'b0;
        compare_en = 1'b1;
        applyStimulus();
        checkOutput("idle_pc_we", {31'd0, pc_we}, 32'd1);
        nextCycle();

`ifdef FORWARD_EN
        // Load-use: one-cycle stall with a bubble into EX.
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        applyStimulus();
        checkOutput("lu_pc_we", {31'd0, pc_we}, 32'd0);
        checkOutput("lu_ifid_we", {31'd0, ifid_we}, 32'd0);
        checkOutput("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
        nextCycle();
        clearInputs();
        applyStimulus();
        checkOutput("lu_stall_cycles", stall_cycles, 32'd1);
        nextCycle();
        // Forwarding selects.
        ex_regwrite = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
        applyStimulus();
        checkOutput("fwd_ex_pc_we", {31'd0, pc_we}, 32'd1);
        checkOutput("fwd_ex_b", {30'd0, fwd_b}, 32'd2);
        nextCycle();
        ex_regwrite = 1'b0; mem_regwrite = 1'b1; mem_rd = 5'd9;
        applyStimulus();
        checkOutput("fwd_mem_b", {30'd0, fwd_b}, 32'd1);
        nextCycle();
        clearInputs();
        ex_regwrite = 1'b1; ex_rd = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
        applyStimulus();
        checkOutput("fwd_r0_b", {30'd0, fwd_b}, 32'd0);
        checkOutput("fwd_r0_pc_we", {31'd0, pc_we}, 32'd1);
        nextCycle();
`else
        // RAW with no bypass: stall while the writer is in EX and then MEM.
        ex_regwrite = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
        applyStimulus();
        checkOutput("raw_c1_pc_we", {31'd0, pc_we}, 32'd0);
        checkOutput("raw_c1_idex_flush", {31'd0, idex_flush}, 32'd1);
        checkOutput("raw_c1_fwd_a", {30'd0, fwd_a}, 32'd0);
        nextCycle();
        ex_regwrite = 1'b0; ex_rd = 5'd0; mem_regwrite = 1'b1; mem_rd = 5'd9;
        applyStimulus();
        checkOutput("raw_c2_pc_we", {31'd0, pc_we}, 32'd0);
        nextCycle();
        mem_regwrite = 1'b0; mem_rd = 5'd0;
        applyStimulus();
        checkOutput("raw_c3_pc_we", {31'd0, pc_we}, 32'd1);
        checkOutput("raw_stall_cycles", stall_cycles, 32'd2);
        nextCycle();
        clearInputs();
`endif
        // Taken branch beats a load-use hazard.
        clearInputs();
        ex_br_taken = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8;
        id_rs = 5'd8; id_use_rs = 1'b1;
        applyStimulus();
        checkOutput("br_pc_we", {31'd0, pc_we}, 32'd1);
        checkOutput("br_ifid_flush", {31'd0, ifid_flush}, 32'd1);
        checkOutput("br_idex_flush", {31'd0, idex_flush}, 32'd1);
        checkOutput("br_exmem_flush", {31'd0, exmem_flush}, 32'd0);
        nextCycle();
        clearInputs();

        // Three wait states, then ready advances the pipe in the same cycle.
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("mw_exmem_we", {31'd0, exmem_we}, 32'd0);
            checkOutput("mw_memwb_flush", {31'd0, memwb_flush}, 32'd1);
            nextCycle();
        end
        dmem_ready = 1'b1;
        applyStimulus();
        checkOutput("mw_ready_exmem_we", {31'd0, exmem_we}, 32'd1);
        checkOutput("mw_ready_memwb_flush", {31'd0, memwb_flush}, 32'd0);
        nextCycle();
        clearInputs();
        applyStimulus();
        nextCycle();

        // Watchdog: entry cycle plus sixteen waiting cycles trips the flag.
        dmem_req = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            applyStimulus();
            if (i == 17) checkOutput("wd_before_trip", {31'd0, mem_timeout}, 32'd0);
            nextCycle();
        end
        dmem_ready = 1'b1;
        applyStimulus();
        checkOutput("wd_tripped", {31'd0, mem_timeout}, 32'd1);
        nextCycle();
        clearInputs();
        applyStimulus();
        checkOutput("wd_sticky", {31'd0, mem_timeout}, 32'd1);
        nextCycle();

        // Asynchronous reset while waiting on memory.
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            nextCycle();
        end
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mw_memwb_we", {31'd0, memwb_we}, 32'd0);
        checkOutput("rst_mw_timeout", {31'd0, mem_timeout}, 32'd0);
        checkOutput("rst_mw_stall_cycles", stall_cycles, 32'd0);
        nextCycle();
        clearInputs();
        rst = 1'b0;
        applyStimulus();
        checkOutput("rst_mw_run_pc_we", {31'd0, pc_we}, 32'd1);
        nextCycle();

        // Randomized traffic, small register range to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            ex_regwrite  = 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            ex_br_taken  = ($urandom_range(0, 7) == 0);
            dmem_req     = ($urandom_range(0, 3) == 0);
            dmem_ready   = 1'($urandom_range(0, 1));
            applyStimulus();
            nextCycle();
        end

        compare_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
